// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, FSM state type and default sizing for the load/store unit.
package mem_pkg;
   localparam int BITS_SIZE_DEF     = 32;
   localparam int SIZE_MEM_DATA_DEF = 10;
   localparam int MEM_LATENCY_DEF   = 2;
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_RSVD = 2'b10,
      SZ_WORD = 2'b11
   } size_e;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: pipeline-side request/response bundle of the load/store unit.
interface mem_lsu_if #(parameter int BITS_SIZE = 32);
   logic                 i_step;
   logic [BITS_SIZE-1:0] i_exmem_alu;
   logic                 i_exmem_mem_read;
   logic                 i_exmem_mem_write;
   logic [BITS_SIZE-1:0] i_exmem_mem_register2;
   logic [1:0]           i_exmem_size_filter;
   logic                 i_exmem_unsigned;
   logic [BITS_SIZE-1:0] i_addr_mem_debug;
   logic [BITS_SIZE-1:0] o_mem_dato;
   logic [BITS_SIZE-1:0] o_mem_dato_debug;
   logic                 o_mem_stall;
   logic                 o_mem_valid;
   logic                 o_mem_fault;
   modport master (
      output i_step, i_exmem_alu, i_exmem_mem_read, i_exmem_mem_write, i_exmem_mem_register2,
             i_exmem_size_filter, i_exmem_unsigned, i_addr_mem_debug,
      input  o_mem_dato, o_mem_dato_debug, o_mem_stall, o_mem_valid, o_mem_fault
   );
   modport slave (
      input  i_step, i_exmem_alu, i_exmem_mem_read, i_exmem_mem_write, i_exmem_mem_register2,
             i_exmem_size_filter, i_exmem_unsigned, i_addr_mem_debug,
      output o_mem_dato, o_mem_dato_debug, o_mem_stall, o_mem_valid, o_mem_fault
   );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian byte-lane steering, load extension and alignment check.
module mem_lane_align
   import mem_pkg::*;
#(parameter int BITS_SIZE = 32) (
   input  size_e                size,
   input  logic [1:0]           lane,
   input  logic                 uns,
   input  logic [BITS_SIZE-1:0] store_data,
   input  logic [BITS_SIZE-1:0] rd_word,
   output logic                 legal,
   output logic [3:0]           be,
   output logic [BITS_SIZE-1:0] wr_data,
   output logic [BITS_SIZE-1:0] ld_data
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = rd_word[{lane, 3'b000} +: 8];
   assign h = rd_word[{lane[1], 4'b0000} +: 16];
   assign legal = size != SZ_RSVD && !(size == SZ_HALF && lane[0]) && !(size == SZ_WORD && lane != 2'b00);
   assign be = size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? 4'b0011 << lane : 4'b1111;
   // replicating store data lets the byte enables alone select the destination lanes
   assign wr_data = size == SZ_BYTE ? {(BITS_SIZE/8){store_data[7:0]}} :
                    size == SZ_HALF ? {(BITS_SIZE/16){store_data[15:0]}} : store_data;
   assign ld_data = size == SZ_BYTE ? {{(BITS_SIZE-8){~uns & b[7]}}, b} :
                    size == SZ_HALF ? {{(BITS_SIZE-16){~uns & h[15]}}, h} : rd_word;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: stepped multi-cycle load/store unit over a resettable byte-lane word memory.
module mem_lsu
   import mem_pkg::*;
#(
   parameter int BITS_SIZE     = BITS_SIZE_DEF,
   parameter int SIZE_MEM_DATA = SIZE_MEM_DATA_DEF,
   parameter int MEM_LATENCY   = MEM_LATENCY_DEF
) (
   input logic      i_clk,
   input logic      i_reset,
   mem_lsu_if.slave bus
);
   localparam int DEPTH = 2 ** SIZE_MEM_DATA;
   state_e                   state;
   logic [2:0]               cnt;
   logic [BITS_SIZE-1:0]     mem [DEPTH];
   logic [BITS_SIZE-1:0]     data_q, dato_q, wr_data, ld_data;
   logic [SIZE_MEM_DATA-1:0] idx_q;
   logic [1:0]               lane_q, lane;
   size_e                    size_q, size;
   logic                     uns_q, wr_q, valid_q, fault_q, legal, idle, req, legal_req, unused_bits;
   logic [3:0]               be;
   assign idle = state == IDLE;
   assign req = bus.i_step && (bus.i_exmem_mem_read ^ bus.i_exmem_mem_write);
   // in IDLE the aligner judges the live request; afterwards it steers the latched one
   assign lane = idle ? bus.i_exmem_alu[1:0] : lane_q;
   assign size = idle ? size_e'(bus.i_exmem_size_filter) : size_q;
   assign legal_req = req && legal;
   mem_lane_align #(.BITS_SIZE(BITS_SIZE)) u_align (
      .size, .lane, .uns(uns_q), .store_data(data_q), .rd_word(mem[idx_q]),
      .legal, .be, .wr_data, .ld_data
   );
   assign bus.o_mem_stall = (idle && legal_req) || state == ACCESS;
   assign bus.o_mem_valid = valid_q;
   assign bus.o_mem_fault = fault_q;
   assign bus.o_mem_dato = dato_q;
   assign bus.o_mem_dato_debug = mem[bus.i_addr_mem_debug[SIZE_MEM_DATA+1:2]];
   assign unused_bits = ^{bus.i_exmem_alu[BITS_SIZE-1:SIZE_MEM_DATA+2],
                          bus.i_addr_mem_debug[BITS_SIZE-1:SIZE_MEM_DATA+2], bus.i_addr_mem_debug[1:0]};
   always_ff @(posedge i_clk)
      if (i_reset) begin
         state <= IDLE;
         cnt <= '0;
         dato_q <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (bus.i_step) begin
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         case (state)
            IDLE:
               if (legal_req) begin
                  idx_q <= bus.i_exmem_alu[SIZE_MEM_DATA+1:2];
                  lane_q <= bus.i_exmem_alu[1:0];
                  size_q <= size_e'(bus.i_exmem_size_filter);
                  data_q <= bus.i_exmem_mem_register2;
                  uns_q <= bus.i_exmem_unsigned;
                  wr_q <= bus.i_exmem_mem_write;
                  cnt <= 3'(MEM_LATENCY - 1);
                  state <= ACCESS;
               end else
                  fault_q <= bus.i_exmem_mem_read | bus.i_exmem_mem_write;
            ACCESS:
               if (cnt == 3'd0) begin
                  if (wr_q) begin
                     for (int b = 0; b < 4; b++)
                        if (be[b]) mem[idx_q][8*b +: 8] <= wr_data[8*b +: 8];
                  end else
                     dato_q <= ld_data;
                  valid_q <= 1'b1;
                  state <= DONE;
               end else
                  cnt <= cnt - 3'd1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed load/store sequence with a queue of expected load results.
module tb_mem_lsu;
   import mem_pkg::*;
   localparam int LAT = MEM_LATENCY_DEF;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_assert = 0;
   int n_fail = 0;
   logic [31:0] exp_q [$];
   always #5 clk = ~clk;
   mem_lsu_if #(.BITS_SIZE(32)) bus ();
   mem_lsu #(.BITS_SIZE(32), .SIZE_MEM_DATA(10), .MEM_LATENCY(LAT)) dut (
      .i_clk(clk), .i_reset(rst), .bus(bus)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic op(input string tag, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz, input logic u,
                     input logic [31:0] e, input int hold);
      int n = 0;
      logic stall_ok = 1'b1;
      logic [31:0] x;
      bus.i_exmem_mem_read = r;
      bus.i_exmem_mem_write = w;
      bus.i_exmem_alu = a;
      bus.i_exmem_mem_register2 = d;
      bus.i_exmem_size_filter = sz;
      bus.i_exmem_unsigned = u;
      bus.i_step = 1'b1;
      if (r) exp_q.push_back(e);
      #1 chk({tag, "_stall_req"}, 32'(bus.o_mem_stall), 1);
      @(posedge clk); #1;
      bus.i_exmem_mem_read = 1'b0;
      bus.i_exmem_mem_write = 1'b0;
      bus.i_step = hold == 0;
      repeat (hold) begin
         chk({tag, "_stall_frozen"}, 32'(bus.o_mem_stall), 1);
         @(posedge clk); #1;
         n++;
      end
      bus.i_step = 1'b1;
      while (!bus.o_mem_valid && n < 20) begin
         if (bus.o_mem_stall !== 1'b1) stall_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n + 1, LAT + hold + 1);
      chk({tag, "_stall_access"}, 32'(stall_ok), 1);
      chk({tag, "_stall_done"}, 32'(bus.o_mem_stall), 0);
      if (r) begin
         x = exp_q.pop_front();
         chk({tag, "_dato"}, bus.o_mem_dato, x);
      end
      @(posedge clk); #1;
      chk({tag, "_valid_end"}, 32'(bus.o_mem_valid), 0);
   endtask
   task automatic bad(input string tag, input logic r, input logic w, input logic [31:0] a,
                      input logic [1:0] sz, input logic frz);
      bus.i_exmem_mem_read = r;
      bus.i_exmem_mem_write = w;
      bus.i_exmem_alu = a;
      bus.i_exmem_size_filter = sz;
      bus.i_step = 1'b1;
      #1 chk({tag, "_stall"}, 32'(bus.o_mem_stall), 0);
      @(posedge clk); #1;
      chk({tag, "_fault"}, 32'(bus.o_mem_fault), 1);
      bus.i_exmem_mem_read = 1'b0;
      bus.i_exmem_mem_write = 1'b0;
      if (frz) begin
         bus.i_step = 1'b0;
         @(posedge clk); #1;
         chk({tag, "_fault_frozen"}, 32'(bus.o_mem_fault), 1);
         bus.i_step = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, "_fault_end"}, 32'(bus.o_mem_fault), 0);
   endtask
   initial begin
      bus.i_step = 1'b0;
      bus.i_exmem_mem_read = 1'b0;
      bus.i_exmem_mem_write = 1'b0;
      bus.i_exmem_alu = '0;
      bus.i_exmem_mem_register2 = '0;
      bus.i_exmem_size_filter = 2'b00;
      bus.i_exmem_unsigned = 1'b0;
      bus.i_addr_mem_debug = 32'h10;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_dato", bus.o_mem_dato, 0);
      chk("rst_valid", 32'(bus.o_mem_valid), 0);
      chk("rst_fault", 32'(bus.o_mem_fault), 0);
      chk("rst_stall", 32'(bus.o_mem_stall), 0);
      chk("rst_mem", bus.o_mem_dato_debug, 0);
      op("st_w", 0, 1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, 0, 0);
      chk("dbg_w", bus.o_mem_dato_debug, 32'hDEADBEEF);
      op("ld_w", 1, 0, 32'h10, 0, SZ_WORD, 0, 32'hDEADBEEF, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst2_mem", bus.o_mem_dato_debug, 0);
      chk("rst2_dato", bus.o_mem_dato, 0);
      op("st_b", 0, 1, 32'h13, 32'h80, SZ_BYTE, 0, 0, 0);
      op("ld_bs", 1, 0, 32'h13, 0, SZ_BYTE, 0, 32'hFFFFFF80, 0);
      op("ld_bu", 1, 0, 32'h13, 0, SZ_BYTE, 1, 32'h00000080, 0);
      chk("dbg_b", bus.o_mem_dato_debug, 32'h80000000);
      op("st_h", 0, 1, 32'h16, 32'hABCD8001, SZ_HALF, 0, 0, 0);
      chk("dato_hold", bus.o_mem_dato, 32'h00000080);
      bus.i_addr_mem_debug = 32'h14;
      chk("dbg_h", bus.o_mem_dato_debug, 32'h80010000);
      op("ld_hs", 1, 0, 32'h16, 0, SZ_HALF, 0, 32'hFFFF8001, 0);
      op("ld_hu", 1, 0, 32'h16, 0, SZ_HALF, 1, 32'h00008001, 0);
      op("ld_b2", 1, 0, 32'h16, 0, SZ_BYTE, 0, 32'h00000001, 0);
      bus.i_exmem_mem_register2 = 32'hFFFFFFFF;
      bad("f_half", 1, 0, 32'h11, SZ_HALF, 0);
      bad("f_word", 1, 0, 32'h12, SZ_WORD, 0);
      bad("f_rsvd", 1, 0, 32'h10, SZ_RSVD, 0);
      bad("f_both", 1, 1, 32'h10, SZ_WORD, 1);
      bad("f_st_half", 0, 1, 32'h11, SZ_HALF, 0);
      bad("f_st_rsvd", 0, 1, 32'h10, SZ_RSVD, 0);
      bus.i_addr_mem_debug = 32'h10;
      chk("f_mem", bus.o_mem_dato_debug, 32'h80000000);
      op("st_wrap", 0, 1, 32'h1000, 32'hCAFEF00D, SZ_WORD, 0, 0, 0);
      bus.i_addr_mem_debug = 32'h0;
      chk("dbg_wrap", bus.o_mem_dato_debug, 32'hCAFEF00D);
      op("ld_hold", 1, 0, 32'h1000, 0, SZ_WORD, 0, 32'hCAFEF00D, 3);
      bus.i_addr_mem_debug = 32'h20;
      bus.i_exmem_mem_write = 1'b1;
      bus.i_exmem_alu = 32'h20;
      bus.i_exmem_mem_register2 = 32'h12345678;
      bus.i_exmem_size_filter = SZ_WORD;
      bus.i_step = 1'b1;
      @(posedge clk); #1;
      bus.i_exmem_mem_write = 1'b0;
      chk("abort_stall", 32'(bus.o_mem_stall), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("abort_valid", 32'(bus.o_mem_valid), 0);
         @(posedge clk); #1;
      end
      chk("abort_mem", bus.o_mem_dato_debug, 0);
      chk("abort_stall_end", 32'(bus.o_mem_stall), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter BITS_SIZE, default 32: data and address width in bits.
REQ-002 Parameter SIZE_MEM_DATA, default 10: word-address bits; depth is 2**SIZE_MEM_DATA words.
REQ-003 Parameter MEM_LATENCY, default 2, legal range 1..7: cycles from acceptance to completion.
REQ-004 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_step  in  1  advance enable; when low, FSM, counter and memory hold.
REQ-007 i_exmem_alu  in  BITS_SIZE  byte address of the access.
REQ-008 i_exmem_mem_read  in  1  load request.
REQ-009 i_exmem_mem_write  in  1  store request.
REQ-010 i_exmem_mem_register2  in  BITS_SIZE  store data, right-justified.
REQ-011 i_exmem_size_filter  in  2  access size: 00 byte, 01 half, 11 word, 10 reserved.
REQ-012 i_exmem_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-013 i_addr_mem_debug  in  BITS_SIZE  debug byte address.
REQ-014 o_mem_dato  out  BITS_SIZE  extended load result.
REQ-015 o_mem_dato_debug  out  BITS_SIZE  full word at the debug address.
REQ-016 o_mem_stall  out  1  pipeline hold request.
REQ-017 o_mem_valid  out  1  one-cycle completion pulse.
REQ-018 o_mem_fault  out  1  one-cycle illegal-request pulse.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-020 A request is present when i_step=1 and exactly one of read/write is 1; it is accepted only in IDLE.
REQ-021 A request is legal when the size is not 10, a half access has addr[0]=0, and a word access has addr[1:0]=00.
REQ-022 A legal request in IDLE SHALL latch address, data, size and the unsigned flag, load the counter with MEM_LATENCY-1, and enter ACCESS.
REQ-023 An illegal request, or read=write=1 with i_step=1, SHALL pulse o_mem_fault for one cycle, perform no access and remain in IDLE.
REQ-024 In ACCESS the counter SHALL decrement each cycle with i_step=1; at counter=0 the store commits or the load captures, and the FSM enters DONE.
REQ-025 DONE SHALL assert o_mem_valid for exactly one cycle and return to IDLE; a new request is not accepted in DONE.
REQ-026 o_mem_stall = (IDLE and a legal request is present) or ACCESS, combinationally; it is low in DONE.
REQ-027 A byte/half store SHALL write only the addressed lanes (little-endian, lane = addr[1:0]); other bytes remain unchanged.
REQ-028 A load SHALL extract the addressed lanes and extend them to BITS_SIZE per the latched unsigned flag.
REQ-029 o_mem_dato SHALL update only on load completion and hold its value otherwise, including across stores.
REQ-030 Word index = addr[SIZE_MEM_DATA+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo the depth.
REQ-031 o_mem_dato_debug SHALL be a combinational read of the full word at i_addr_mem_debug, independent of the FSM and of i_step.
REQ-032 With i_step=0 the FSM SHALL freeze in every state, and the pulse outputs SHALL stay high until the next step.
REQ-033 Total latency, acceptance to o_mem_valid, SHALL be MEM_LATENCY+1 stepped cycles.

Reset
REQ-034 On i_reset=1 at a clock edge: FSM to IDLE, counter to 0, all memory words to 0, o_mem_dato to 0, o_mem_valid and o_mem_fault to 0.
REQ-035 Reset SHALL have priority over i_step.
REQ-036 Reset during ACCESS SHALL abort the access: no partial store is committed and no valid pulse follows.

Structure
REQ-037 Package mem_pkg SHALL hold the size encodings, the FSM state type and the default parameter constants.
REQ-038 Sub-module mem_lane_align SHALL be combinational and SHALL generate byte enables, store-data replication, load extraction/extension and the legality check.

Verification
REQ-039 Reset, then word store 0xDEADBEEF @0x10, then word load @0x10 -> o_mem_dato=0xDEADBEEF, valid MEM_LATENCY+1 cycles after acceptance, stall high for the preceding cycles.
REQ-040 Byte store 0x80 @0x13 over 0x00000000, then signed byte load @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; debug read @0x10 -> 0x80000000.
REQ-041 Half load @0x11, word load @0x12, size=10, and read=write=1 -> o_mem_fault pulse each time, stall never high, memory unchanged.
REQ-042 With SIZE_MEM_DATA=10, store @0x1000 -> debug read @0x0 returns the stored word (wrap).
REQ-043 i_step dropped for 3 cycles mid-ACCESS -> state and counter hold, completion delayed by exactly 3 cycles.
REQ-044 Reset asserted in ACCESS of a word store 0x12345678 @0x20 -> no valid pulse, debug read @0x20 returns 0.
